// File: rtl/fifo_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_read_ctrl
// Purpose  : Read side of an 8x16 FIFO; fetches words into a registered
//            valid/ready output stage. Optional FIFO_RD_OVERFLOW_CHK_EN adds a
//            sticky overflow flag on Err.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_read_ctrl (
    input  logic        Clk,
    input  logic        nReset,
    input  logic [3:0]  WrPtr,
    input  logic [15:0] MemData,
    input  logic        Ready,
    input  logic        Flush,
    output logic [2:0]  AddrRead,
    output logic        OE,
    output logic [3:0]  RdPtr,
    output logic [15:0] DataOut,
    output logic        Valid,
    output logic        Empty,
    output logic        Err
);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_VALID = 1'b1;

    logic [0:0]  r_state;
    logic [0:0]  w_nextState;
    logic [3:0]  r_rdPtr;
    logic [15:0] r_dataOut;
    logic [3:0]  w_count;
    logic        w_avail;
    logic        w_load;

    // Pointer difference mod 16 is the number of entries not yet fetched.
    assign w_count = WrPtr - r_rdPtr;
    assign w_avail = (w_count != 4'd0);

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_state   <= S_EMPTY;
            r_rdPtr   <= 4'h0;
            r_dataOut <= 16'h0000;
        end else begin
            r_state <= w_nextState;
            if (Flush) begin
                r_rdPtr <= WrPtr;
            end else if (w_load) begin
                r_rdPtr   <= r_rdPtr + 4'd1;
                r_dataOut <= MemData;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (Flush) begin
            w_nextState = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_avail) w_nextState = S_VALID;
                S_VALID: if (Ready && !w_avail) w_nextState = S_EMPTY;
                default: w_nextState = S_EMPTY;
            endcase
        end
    end

    // A fetch happens when idle, or when the held word is being consumed.
    always_comb begin
        Valid  = (r_state == S_VALID);
        w_load = !Flush && w_avail && ((r_state == S_EMPTY) || Ready);
    end

    assign AddrRead = r_rdPtr[2:0];
    assign RdPtr    = r_rdPtr;
    assign DataOut  = r_dataOut;
    assign OE       = w_avail;
    assign Empty    = !w_avail && !Valid;

`ifdef FIFO_RD_OVERFLOW_CHK_EN
    logic r_err;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_err <= 1'b0;
        end else if (w_count > 4'd8) begin
            r_err <= 1'b1;
        end
    end

    assign Err = r_err;
`else
    assign Err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_read_ctrl
// Purpose  : Self-checking bench for fifo_read_ctrl with a queue scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_read_ctrl;

    logic        Clk = 1'b0;
    logic        nReset = 1'b0;
    logic [3:0]  WrPtr = 4'h0;
    logic [15:0] MemData;
    logic        Ready = 1'b0;
    logic        Flush = 1'b0;
    logic [2:0]  AddrRead;
    logic        OE;
    logic [3:0]  RdPtr;
    logic [15:0] DataOut;
    logic        Valid;
    logic        Empty;
    logic        Err;

    logic [15:0] mem [8];
    logic [15:0] expQ [$];
    int          nCmp = 0;
    int          nFail = 0;
    logic        expErr;

    always #5 Clk = ~Clk;

    assign MemData = mem[AddrRead];

    fifo_read_ctrl dut (
        .Clk      (Clk),
        .nReset   (nReset),
        .WrPtr    (WrPtr),
        .MemData  (MemData),
        .Ready    (Ready),
        .Flush    (Flush),
        .AddrRead (AddrRead),
        .OE       (OE),
        .RdPtr    (RdPtr),
        .DataOut  (DataOut),
        .Valid    (Valid),
        .Empty    (Empty),
        .Err      (Err)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic writeWord(input logic [15:0] data);
        mem[WrPtr[2:0]] = data;
        WrPtr = WrPtr + 4'd1;
        expQ.push_back(data);
    endtask

    task automatic doReset();
        nReset = 1'b0;
        WrPtr  = 4'h0;
        Ready  = 1'b0;
        Flush  = 1'b0;
        expQ.delete();
        tick();
        nReset = 1'b1;
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 60;
        while (expQ.size() != 0 && budget > 0) begin
            @(negedge Clk);
            budget--;
        end
        if (expQ.size() != 0) begin
            nCmp++;
            nFail++;
            $display("FAIL %s drain timeout: %0d words left, expected 0", name, expQ.size());
            expQ.delete();
        end
        tick();
    endtask

    // Scoreboard monitor: a word is delivered when Valid and Ready meet.
    always @(negedge Clk) begin
        if (nReset && Valid && Ready) begin
            if (expQ.size() == 0) begin
                nCmp++;
                nFail++;
                $display("FAIL scoreboard: unexpected word %h, expected none", DataOut);
            end else begin
                chk("scoreboard", DataOut, expQ.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 16'h0000;

        // Reset state, checked asynchronously while nReset is held low
        #2;
        chk("rst_valid", {15'd0, Valid}, 16'd0);
        chk("rst_dataout", DataOut, 16'h0000);
        doReset();
        chk("rst_empty", {15'd0, Empty}, 16'd1);
        chk("rst_rdptr", {12'd0, RdPtr}, 16'd0);
        chk("rst_oe", {15'd0, OE}, 16'd0);
        chk("rst_addr", {13'd0, AddrRead}, 16'd0);
        chk("rst_err", {15'd0, Err}, 16'd0);

        // Single word, one-edge latency
        Ready = 1'b1;
        writeWord(16'hA5A5);
        tick();
        chk("single_valid", {15'd0, Valid}, 16'd1);
        chk("single_data", DataOut, 16'hA5A5);
        chk("single_rdptr", {12'd0, RdPtr}, 16'd1);
        chk("single_empty", {15'd0, Empty}, 16'd0);
        tick();
        chk("single_valid_after", {15'd0, Valid}, 16'd0);
        chk("single_empty_after", {15'd0, Empty}, 16'd1);

        // Fill 8 words while stalled, then stream them out
        doReset();
        for (int i = 1; i <= 8; i++) begin
            writeWord(16'(i));
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_hold", DataOut, 16'h0001);
            chk("stall_valid", {15'd0, Valid}, 16'd1);
        end
        Ready = 1'b1;
        drain("fill8");
        chk("fill8_rdptr", {12'd0, RdPtr}, 16'd8);
        chk("fill8_empty", {15'd0, Empty}, 16'd1);

        // 20 words streamed through the pointer wrap
        doReset();
        Ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            writeWord(16'h0100 + 16'(i));
            tick();
            chk("wrap_rdptr", {12'd0, RdPtr}, 16'((i + 1) % 16));
            chk("wrap_addr", {13'd0, AddrRead}, 16'((i + 1) % 8));
        end
        drain("wrap");

        // Flush with WrPtr=5, RdPtr=1, Valid=1
        doReset();
        for (int i = 0; i < 5; i++) begin
            writeWord(16'h0500 + 16'(i));
            tick();
        end
        chk("preflush_rdptr", {12'd0, RdPtr}, 16'd1);
        Flush = 1'b1;
        expQ.delete();
        tick();
        Flush = 1'b0;
        chk("flush_rdptr", {12'd0, RdPtr}, 16'd5);
        chk("flush_valid", {15'd0, Valid}, 16'd0);
        chk("flush_empty", {15'd0, Empty}, 16'd1);
        chk("flush_dataout", DataOut, 16'h0500);
        writeWord(16'h0BEE);
        Ready = 1'b1;
        drain("postflush");
        chk("postflush_empty", {15'd0, Empty}, 16'd1);

        // Reset mid-transfer abandons the held word immediately
        Ready = 1'b0;
        writeWord(16'h0C0C);
        tick();
        chk("held_valid", {15'd0, Valid}, 16'd1);
        #2;
        nReset = 1'b0;
        expQ.delete();
        #1;
        chk("midrst_valid", {15'd0, Valid}, 16'd0);
        chk("midrst_dataout", DataOut, 16'h0000);
        chk("midrst_rdptr", {12'd0, RdPtr}, 16'd0);
        doReset();

        // Overflow: count of 9
`ifdef FIFO_RD_OVERFLOW_CHK_EN
        expErr = 1'b1;
`else
        expErr = 1'b0;
`endif
        WrPtr = 4'd9;
        tick();
        chk("ovf_err", {15'd0, Err}, {15'd0, expErr});
        WrPtr = RdPtr;
        tick();
        tick();
        chk("ovf_err_sticky", {15'd0, Err}, {15'd0, expErr});
        doReset();
        chk("ovf_err_reset", {15'd0, Err}, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_read_ctrl.md
FIFO_READ_CTRL -- requirements
Module: fifo_read_ctrl

Interface
REQ-001 SHALL have port Clk, input, 1, system clock; all state updates on its rising edge.
REQ-002 SHALL have port nReset, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port WrPtr, input, 4, writer's binary write pointer; bit 3 is the wrap bit and bits 2:0 are the slot; same clock domain.
REQ-004 SHALL have port MemData, input, 16, read data from the 8x16 FIFO memory; combinational read of slot AddrRead.
REQ-005 SHALL have port Ready, input, 1, consumer accepts DataOut this cycle.
REQ-006 SHALL have port Flush, input, 1, discard all unread and held entries.
REQ-007 SHALL have port AddrRead, output, 3, memory read slot; always equals RdPtr[2:0].
REQ-008 SHALL have port OE, output, 1, memory read enable; combinational, high when Count != 0.
REQ-009 SHALL have port RdPtr, output, 4, read pointer returned to the writer for full detection.
REQ-010 SHALL have port DataOut, output, 16, registered output word.
REQ-011 SHALL have port Valid, output, 1, DataOut holds an unconsumed word.
REQ-012 SHALL have port Empty, output, 1, no unread entry and no held word.
REQ-013 SHALL have port Err, output, 1, sticky overflow flag (see Configuration).

Function
REQ-014 SHALL compute Count = (WrPtr - RdPtr) mod 16, giving the number of memory entries not yet fetched; legal range is 0..8.
REQ-015 SHALL implement a 2-state FSM: S_EMPTY (Valid=0) and S_VALID (Valid=1).
REQ-016 SHALL, in S_EMPTY with Count != 0: latch MemData into DataOut, increment RdPtr by 1 (mod 16), and go to S_VALID at the same edge.
REQ-017 SHALL, in S_VALID with Ready=1 and Count != 0: reload DataOut from MemData, increment RdPtr, and stay in S_VALID, sustaining one word per cycle.
REQ-018 SHALL, in S_VALID with Ready=1 and Count=0: go to S_EMPTY with DataOut unchanged.
REQ-019 SHALL, in S_VALID with Ready=0: hold DataOut, RdPtr, and state; DataOut SHALL NOT change while Valid=1 and Ready=0.
REQ-020 SHALL ignore Ready while in S_EMPTY.
REQ-021 SHALL give a latency of one edge: a word written when WrPtr increments at edge N appears with Valid=1 after edge N+1 if the controller was idle.
REQ-022 SHALL wrap RdPtr from 4'hF to 4'h0; the slot wraps from 7 to 0 and the wrap bit toggles.
REQ-023 SHALL drive Empty combinationally as (Count == 0) && !Valid.
REQ-024 SHALL, on Flush=1 at a rising edge, set RdPtr <= WrPtr, go to S_EMPTY, and clear Valid; Flush overrides load and Ready in that cycle.
REQ-025 SHALL keep DataOut at its last value after a flush.
REQ-026 SHALL treat a WrPtr increment in the same cycle as a consume from the last entry as Count=0 for that edge; the new word loads on the next edge.

Reset
REQ-027 SHALL, while nReset=0, asynchronously force RdPtr=4'h0, DataOut=16'h0000, state=S_EMPTY (Valid=0), and Err=0.
REQ-028 SHALL, as a result of reset, present Empty=1 when WrPtr=0, AddrRead=3'b000, and OE=0.
REQ-029 SHALL abandon any held word on reset mid-transfer; no word is delivered twice or partially.

Configuration
REQ-030 SHALL use macro FIFO_RD_OVERFLOW_CHK_EN; when defined, Err SHALL set on any edge where Count > 8 and stay set until reset.
REQ-031 SHALL, when FIFO_RD_OVERFLOW_CHK_EN is not defined, tie Err to 0 and add no logic; all other behaviour is identical.

Verification
REQ-032 SHALL cover: reset with WrPtr=0 -> Valid=0, Empty=1, RdPtr=0, DataOut=16'h0000, OE=0.
REQ-033 SHALL cover: mem[0]=16'hA5A5 and WrPtr 0->1 at edge N, Ready=1 -> after edge N+1 Valid=1, DataOut=16'hA5A5, RdPtr=1, Empty=0; one edge later Valid=0, Empty=1.
REQ-034 SHALL cover: 8 words 16'h0001..16'h0008, WrPtr=8, Ready=0 for 5 cycles then 1 -> DataOut holds 16'h0001 while stalled, then 16'h0002..16'h0008 on consecutive cycles, and RdPtr=8.
REQ-035 SHALL cover: run 20 words with pointers wrapping through 4'hF->4'h0 -> AddrRead follows 7->0, and output order is preserved.
REQ-036 SHALL cover: WrPtr=5, RdPtr=1, Valid=1, Flush pulse -> after the edge RdPtr=5, Valid=0, Empty=1.
REQ-037 SHALL cover: with FIFO_RD_OVERFLOW_CHK_EN defined, force WrPtr=9 while RdPtr=0 -> Err=1 and it stays 1; without the macro, Err=0.
